regfile_wr_demux: RTL and testbench
===================================

Name: regfile_wr_demux

Overview:
- MIPS register file for the single-cycle datapath, built around a 1-to-32 write demultiplexer.
- The write-register address and write-back data arrive from the 5-bit and 32-bit selectors upstream.
- The address decodes into a one-hot write enable that steers the data into exactly one of 32 registers.
- Two asynchronous read ports feed the ALU operand path. Optional write-to-read bypass is provided, and register $0 is hardwired to zero.

Parameters:
- DATA_W, 32, register and data width in bits.
- ADDR_W, 5, register address width; register count is 2**ADDR_W.
- BYPASS, 1, when 1 a same-cycle write to a register being read is forwarded to the read port.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- we  input  1  register write enable from control.
- waddr  input  ADDR_W  destination register (output of the 5-bit selector).
- wdata  input  DATA_W  write-back data (output of the 32-bit selector).
- raddr1  input  ADDR_W  read port 1 address (rs).
- raddr2  input  ADDR_W  read port 2 address (rt).
- rdata1  output  DATA_W  read port 1 data.
- rdata2  output  DATA_W  read port 2 data.
- wr_onehot  output  2**ADDR_W  registered one-hot image of the last accepted write, for debug and verification.

Behaviour:
- Reset:
  - rst_n low asynchronously clears all registers 1..31 and wr_onehot to 0.
  - rdata1 and rdata2 therefore read 0 during reset and after it.
  - Reset asserted mid-write wins; the write is lost.
- Decode:
  - dec[i] = we && (waddr == i) && (i != 0). The decode is combinational and has at most one bit set.
- Write:
  - On a rising clk with rst_n high, reg[i] <= wdata for the single i where dec[i]=1.
  - All other registers hold their values.
  - Write latency is 1 cycle: the value is visible through a normal read in the cycle after the edge.
- wr_onehot:
  - On each rising clk, wr_onehot <= dec. It is all-zero when we=0 or waddr=0.
- $0:
  - Has no storage.
  - Reads of address 0 always return 0, including under bypass.
  - Writes to address 0 are discarded silently and leave wr_onehot all-zero.
- Read:
  - Combinational, 0-cycle latency: rdataN = (raddrN==0) ? 0 : reg[raddrN].
- Bypass (BYPASS=1):
  - If we && waddr==raddrN && raddrN!=0, then rdataN = wdata in the same cycle (write-first).
  - The register itself still updates on the edge.
- Bypass (BYPASS=0):
  - rdataN returns the old contents until the edge.
- Simultaneous cases:
  - Both read ports may address the same register, or the register being written; each port resolves independently.
  - Back-to-back writes to the same register: the last write wins.
- Width:
  - No sign or zero extension; data is stored and returned bit-exact.
- State machine:
  - None beyond the per-register storage. The block is a pure storage and demux element with no stall or handshake: every enabled write is accepted.

Test Plan:
- Reset behaviour: assert rst_n=0 mid-cycle after writing reg5=0xDEADBEEF -> immediately rdata1 (raddr1=5)=0 and wr_onehot=0, without waiting for clk.
- Basic write/read: we=1, waddr=8, wdata=0x12345678 for one edge; then raddr1=8, raddr2=8 -> both read 0x12345678; wr_onehot=0x00000100.
- Register $0 protection: we=1, waddr=0, wdata=0xFFFFFFFF -> raddr1=0 reads 0 before and after the edge; wr_onehot=0.
- Bypass: BYPASS=1, reg9=0x1, we=1, waddr=9, wdata=0xA5A5A5A5, raddr2=9 -> rdata2=0xA5A5A5A5 before the edge. With BYPASS=0 -> rdata2=0x1 until the edge.
- Decode exhaustiveness: write i*0x01010101 to each address 1..31 in turn -> each wr_onehot equals 1<<i. A readback sweep returns the exact values, and no register is corrupted by writes to other addresses.
- we gating: we=0, waddr=3, wdata=0x55 -> reg3 is unchanged and wr_onehot=0.

Source files
------------

// File: rtl/regfile_wr_demux.sv
// -----------------------------------------------------------------------------
// regfile_wr_demux
//
// Register file for a single-cycle MIPS datapath. It is built around a
// 1-to-2**ADDR_W write demultiplexer. The write address decodes into a
// one-hot enable, and that enable steers the write-back data into exactly
// one register. Two combinational read ports feed the ALU operands.
// Register $0 has no storage and always reads as zero. An optional bypass
// forwards a same-cycle write to any read port that addresses the register
// being written.
//
// Ports:
//   clk        in   system clock, rising-edge active
//   rst_n      in   asynchronous active-low reset (clears regs 1..N-1, wr_onehot)
//   we         in   register write enable
//   waddr      in   destination register address
//   wdata      in   write-back data
//   raddr1     in   read port 1 address (rs)
//   raddr2     in   read port 2 address (rt)
//   rdata1     out  read port 1 data (combinational)
//   rdata2     out  read port 2 data (combinational)
//   wr_onehot  out  registered one-hot image of the last accepted write
// -----------------------------------------------------------------------------
module regfile_wr_demux #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int BYPASS = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 we,
    input  logic [ADDR_W-1:0]    waddr,
    input  logic [DATA_W-1:0]    wdata,
    input  logic [ADDR_W-1:0]    raddr1,
    input  logic [ADDR_W-1:0]    raddr2,
    output logic [DATA_W-1:0]    rdata1,
    output logic [DATA_W-1:0]    rdata2,
    output logic [2**ADDR_W-1:0] wr_onehot
);

    localparam int NREG = 2**ADDR_W;

    // Storage exists only for registers 1..NREG-1; $0 is synthesised as a constant.
    logic [DATA_W-1:0] regs_q [1:NREG-1];
    logic [NREG-1:0]   wr_onehot_q;
    logic [NREG-1:0]   wr_onehot_d;

    // Write demux: at most one bit set. Bit 0 is never set, so writes to $0
    // are dropped and also leave the debug image all-zero.
    always_comb begin
        // NOTE: default-assign every always_comb output first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        wr_onehot_d = '0;
        for (int i = 1; i < NREG; i++) begin
            if (we && (waddr == ADDR_W'(i))) begin
                wr_onehot_d[i] = 1'b1;
            end
        end
    end

    // NOTE: the register array is reset here because reads must return 0
    // after reset. Plain RAM-style arrays are normally left unreset, but this
    // one is a flop array.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
            wr_onehot_q <= '0;
        end else begin
            // NOTE: use non-blocking assignments for all state so every
            // register samples pre-edge values, whatever the statement order.
            wr_onehot_q <= wr_onehot_d;
            for (int i = 1; i < NREG; i++) begin
                if (wr_onehot_d[i]) begin
                    regs_q[i] <= wdata;
                end
            end
        end
    end

    // Read mux. Address 0 falls through to the zero default. With bypass
    // enabled, a matching write is forwarded to the port (write-first). The
    // forward is gated by addr != 0 so that $0 stays zero even under bypass.
    function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] addr);
        logic [DATA_W-1:0] val;
        val = '0;
        for (int i = 1; i < NREG; i++) begin
            if (addr == ADDR_W'(i)) begin
                val = regs_q[i];
            end
        end
        if ((BYPASS != 0) && we && (waddr == addr) && (addr != '0)) begin
            val = wdata;
        end
        return val;
    endfunction

    always_comb begin
        rdata1 = read_port(raddr1);
        rdata2 = read_port(raddr2);
    end

    assign wr_onehot = wr_onehot_q;

endmodule

// File: tb/tb_regfile_wr_demux.sv
// -----------------------------------------------------------------------------
// tb_regfile_wr_demux
//
// Directed testbench for regfile_wr_demux. Two instances share one set of
// inputs: u_byp has BYPASS=1 and u_nob has BYPASS=0. This lets each stimulus
// check both the forwarding and the non-forwarding read behaviour. Inputs
// change just after the falling edge. Outputs are sampled 1 ns after a change
// or after the rising edge.
// -----------------------------------------------------------------------------
module tb_regfile_wr_demux;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    logic              clk;
    logic              rst_n;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic [ADDR_W-1:0] raddr1;
    logic [ADDR_W-1:0] raddr2;

    logic [DATA_W-1:0] rd1_b, rd2_b, rd1_n, rd2_n;
    logic [31:0]       oh_b, oh_n;

    int errors = 0;
    int checks = 0;

    regfile_wr_demux #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS(1)) u_byp (
        .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr1(raddr1), .raddr2(raddr2),
        .rdata1(rd1_b), .rdata2(rd2_b), .wr_onehot(oh_b)
    );

    regfile_wr_demux #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS(0)) u_nob (
        .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr1(raddr1), .raddr2(raddr2),
        .rdata1(rd1_n), .rdata2(rd2_n), .wr_onehot(oh_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one write through a single rising edge. This task makes no checks.
    task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        @(negedge clk);
        we = 1'b1; waddr = a; wdata = d;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        // Reset is asserted from time 0.
        #1;
        checks++; if (rd1_b !== 32'h0) begin errors++; $display("FAIL reset_rd1 got=%h exp=%h", rd1_b, 32'h0); end
        checks++; if (oh_b !== 32'h0) begin errors++; $display("FAIL reset_onehot got=%h exp=%h", oh_b, 32'h0); end
        @(negedge clk); rst_n = 1'b1;
        do_write(5'd5, 32'hDEADBEEF);
        @(negedge clk);
        we = 1'b0; raddr1 = 5'd5;
        #1;
        checks++; if (rd1_n !== 32'hDEADBEEF) begin errors++; $display("FAIL reset_prewrite got=%h exp=%h", rd1_n, 32'hDEADBEEF); end
        // Reset is asserted mid-cycle. Its effect must be immediate, with no
        // clock edge needed.
        rst_n = 1'b0;
        #1;
        checks++; if (rd1_b !== 32'h0) begin errors++; $display("FAIL reset_async_rd1_byp got=%h exp=%h", rd1_b, 32'h0); end
        checks++; if (rd1_n !== 32'h0) begin errors++; $display("FAIL reset_async_rd1_nob got=%h exp=%h", rd1_n, 32'h0); end
        // A write attempted while reset is held is lost.
        we = 1'b1; waddr = 5'd6; wdata = 32'hCAFEF00D;
        @(posedge clk); #1;
        checks++; if (oh_n !== 32'h0) begin errors++; $display("FAIL reset_onehot_held got=%h exp=%h", oh_n, 32'h0); end
        @(negedge clk);
        we = 1'b0; rst_n = 1'b1; raddr1 = 5'd6;
        #1;
        checks++; if (rd1_n !== 32'h0) begin errors++; $display("FAIL reset_write_lost got=%h exp=%h", rd1_n, 32'h0); end
    endtask

    task automatic test_basic_write();
        do_write(5'd8, 32'h12345678);
        checks++; if (oh_b !== 32'h0000_0100) begin errors++; $display("FAIL basic_onehot got=%h exp=%h", oh_b, 32'h0000_0100); end
        @(negedge clk);
        we = 1'b0; raddr1 = 5'd8; raddr2 = 5'd8;
        #1;
        checks++; if (rd1_n !== 32'h12345678) begin errors++; $display("FAIL basic_rd1 got=%h exp=%h", rd1_n, 32'h12345678); end
        checks++; if (rd2_n !== 32'h12345678) begin errors++; $display("FAIL basic_rd2 got=%h exp=%h", rd2_n, 32'h12345678); end
        checks++; if (rd1_b !== 32'h12345678) begin errors++; $display("FAIL basic_rd1_byp got=%h exp=%h", rd1_b, 32'h12345678); end
    endtask

    task automatic test_zero_reg();
        @(negedge clk);
        we = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF; raddr1 = 5'd0; raddr2 = 5'd0;
        #1;
        checks++; if (rd1_b !== 32'h0) begin errors++; $display("FAIL zero_pre_byp got=%h exp=%h", rd1_b, 32'h0); end
        @(posedge clk); #1;
        checks++; if (oh_b !== 32'h0) begin errors++; $display("FAIL zero_onehot got=%h exp=%h", oh_b, 32'h0); end
        checks++; if (rd1_b !== 32'h0) begin errors++; $display("FAIL zero_post_byp got=%h exp=%h", rd1_b, 32'h0); end
        checks++; if (rd2_n !== 32'h0) begin errors++; $display("FAIL zero_post_nob got=%h exp=%h", rd2_n, 32'h0); end
        @(negedge clk); we = 1'b0;
    endtask

    task automatic test_bypass();
        do_write(5'd9, 32'h0000_0001);
        @(negedge clk);
        we = 1'b1; waddr = 5'd9; wdata = 32'hA5A5A5A5; raddr2 = 5'd9; raddr1 = 5'd8;
        #1;
        checks++; if (rd2_b !== 32'hA5A5A5A5) begin errors++; $display("FAIL bypass_fwd got=%h exp=%h", rd2_b, 32'hA5A5A5A5); end
        checks++; if (rd2_n !== 32'h0000_0001) begin errors++; $display("FAIL bypass_off_old got=%h exp=%h", rd2_n, 32'h1); end
        // The other port must resolve independently of the forward.
        checks++; if (rd1_b !== 32'h12345678) begin errors++; $display("FAIL bypass_other_port got=%h exp=%h", rd1_b, 32'h12345678); end
        @(posedge clk); #1;
        checks++; if (rd2_n !== 32'hA5A5A5A5) begin errors++; $display("FAIL bypass_off_after_edge got=%h exp=%h", rd2_n, 32'hA5A5A5A5); end
        @(negedge clk); we = 1'b0;
        #1;
        checks++; if (rd2_b !== 32'hA5A5A5A5) begin errors++; $display("FAIL bypass_reg_updated got=%h exp=%h", rd2_b, 32'hA5A5A5A5); end
    endtask

    task automatic test_decode_sweep();
        logic [31:0] exp_oh;
        logic [31:0] exp_d;
        for (int i = 1; i < 32; i++) begin
            exp_d  = 32'(i) * 32'h01010101;
            exp_oh = 32'h1 << i;
            do_write(ADDR_W'(i), exp_d);
            checks++; if (oh_b !== exp_oh) begin errors++; $display("FAIL decode_onehot[%0d] got=%h exp=%h", i, oh_b, exp_oh); end
        end
        @(negedge clk); we = 1'b0;
        for (int i = 0; i < 32; i++) begin
            exp_d = 32'(i) * 32'h01010101;
            raddr1 = ADDR_W'(i);
            raddr2 = ADDR_W'(31 - i);
            #1;
            checks++; if (rd1_n !== exp_d) begin errors++; $display("FAIL sweep_rd1[%0d] got=%h exp=%h", i, rd1_n, exp_d); end
            checks++; if (rd2_b !== 32'(31 - i) * 32'h01010101) begin
                errors++; $display("FAIL sweep_rd2[%0d] got=%h exp=%h", 31 - i, rd2_b, 32'(31 - i) * 32'h01010101);
            end
        end
    endtask

    task automatic test_we_gating();
        @(negedge clk);
        we = 1'b0; waddr = 5'd3; wdata = 32'h55; raddr1 = 5'd3;
        #1;
        checks++; if (rd1_b !== 32'h03030303) begin errors++; $display("FAIL we_gate_pre got=%h exp=%h", rd1_b, 32'h03030303); end
        @(posedge clk); #1;
        checks++; if (rd1_n !== 32'h03030303) begin errors++; $display("FAIL we_gate_post got=%h exp=%h", rd1_n, 32'h03030303); end
        checks++; if (oh_n !== 32'h0) begin errors++; $display("FAIL we_gate_onehot got=%h exp=%h", oh_n, 32'h0); end
    endtask

    task automatic test_back_to_back();
        do_write(5'd12, 32'h1111_1111);
        do_write(5'd12, 32'h2222_2222);
        checks++; if (oh_n !== 32'h0000_1000) begin errors++; $display("FAIL b2b_onehot got=%h exp=%h", oh_n, 32'h0000_1000); end
        do_write(5'd31, 32'h8000_0001);
        checks++; if (oh_b !== 32'h8000_0000) begin errors++; $display("FAIL b2b_onehot31 got=%h exp=%h", oh_b, 32'h8000_0000); end
        @(negedge clk);
        we = 1'b0; raddr1 = 5'd12; raddr2 = 5'd31;
        #1;
        checks++; if (rd1_n !== 32'h2222_2222) begin errors++; $display("FAIL b2b_last_wins got=%h exp=%h", rd1_n, 32'h2222_2222); end
        checks++; if (rd2_n !== 32'h8000_0001) begin errors++; $display("FAIL b2b_reg31 got=%h exp=%h", rd2_n, 32'h8000_0001); end
        raddr1 = 5'd11; raddr2 = 5'd13;
        #1;
        checks++; if (rd1_n !== 32'h0B0B0B0B) begin errors++; $display("FAIL b2b_neighbor11 got=%h exp=%h", rd1_n, 32'h0B0B0B0B); end
        checks++; if (rd2_n !== 32'h0D0D0D0D) begin errors++; $display("FAIL b2b_neighbor13 got=%h exp=%h", rd2_n, 32'h0D0D0D0D); end
    endtask

    initial begin
        rst_n = 1'b0; we = 1'b0; waddr = '0; wdata = '0; raddr1 = '0; raddr2 = '0;
        test_reset();
        test_basic_write();
        test_zero_reg();
        test_bypass();
        test_decode_sweep();
        test_we_gating();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
